// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the memory port arbiter.
//   MEMORY_SIZE  : size of the attached RAM in bytes. Any byte address at or
//                  above this value is answered with an error and never
//                  reaches the memory.
//   arb_state    : IDLE / ISSUE / WAIT / RESP sequencing of one access.
//   arb_owner    : which requester owns the access in flight.
package mem_port_arbiter_pkg;

    localparam logic [31:0] MEMORY_SIZE = 32'h0001_0000;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INSTR,
        OWN_DATA
    } arb_owner;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every handshake and memory-bus signal of the arbiter.
//   Fetch side : i_req, i_addr -> i_ack, i_rdata, i_err
//   Data side  : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata, d_err
//   Memory side: mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   Status     : busy
// Modport slave is the arbiter's view; modport master is the view of the
// requesters plus the RAM model sitting around it.
interface mem_port_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output i_ack, i_rdata, i_err,
        output d_ack, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  i_ack, i_rdata, i_err,
        input  d_ack, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch and load/store. Each
// access walks IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP, and
// out-of-range addresses short-cut IDLE -> RESP with an error. Data wins
// a simultaneous request. All outputs are registered.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous, active-high; abandons any access in flight
//   bus   : mem_port_arbiter_if.slave (fetch, data and memory signals)
// Parameters:
//   MEM_LATENCY     : cycles from mem_en to valid mem_rdata (>= 1)
//   MAX_DATA_STREAK : data grants allowed while fetch waits
// Build option:
//   MEM_ARB_FAIRNESS_EN : adds a streak counter so that after
//   MAX_DATA_STREAK data grants with fetch waiting, fetch gets the port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    if (MEM_LATENCY < 1 || MAX_DATA_STREAK < 1) begin : g_param_check
        $error("mem_port_arbiter: MEM_LATENCY and MAX_DATA_STREAK must be >= 1");
    end

    arb_state           state_q, state_d;
    arb_owner           owner_q, owner_d;
    logic [3:0]         we_q, we_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

    logic               i_ack_q, i_ack_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic               i_err_q, i_err_d;
    logic               d_ack_q, d_ack_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               d_err_q, d_err_d;
    logic               mem_en_q, mem_en_d;
    logic [3:0]         mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               busy_q, busy_d;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    logic [STREAK_W-1:0] streak_q, streak_d;
`endif

    logic               take_data;
    logic [31:0]        grant_addr;
    logic [3:0]         grant_we;
    logic [31:0]        grant_wdata;
    logic               resp_fire;
    logic               resp_err;
    logic [31:0]        resp_data;
    arb_owner           resp_owner;

    // Next-state and next-output logic. Pulses (acks, mem_en) and the write
    // strobe default low every cycle; everything else holds. Completions
    // from both the error short-cut and the end of WAIT are funnelled
    // through resp_* so the per-port result registers are written in one
    // place, and only for the owning port, so the other port's rdata/err
    // keep their last values.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        lat_cnt_d   = lat_cnt_q;
        i_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        i_err_d     = i_err_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_addr  = 32'h0;
        grant_we    = 4'b0000;
        grant_wdata = 32'h0;
        resp_fire   = 1'b0;
        resp_err    = 1'b0;
        resp_data   = 32'h0;
        resp_owner  = owner_q;

`ifdef MEM_ARB_FAIRNESS_EN
        streak_d  = streak_q;
        // Fetch is forced through once data has hogged the port long enough.
        take_data = bus.d_req &&
                    !(bus.i_req && (streak_q == STREAK_W'(MAX_DATA_STREAK)));
`else
        take_data = bus.d_req;
`endif

        case (state_q)
            ARB_IDLE: begin
                if (bus.d_req || bus.i_req) begin
                    // A fetch never writes, so its latched enables are zero.
                    if (take_data) begin
                        owner_d     = OWN_DATA;
                        grant_addr  = bus.d_addr;
                        grant_we    = bus.d_we;
                        grant_wdata = bus.d_wdata;
                    end else begin
                        owner_d     = OWN_INSTR;
                        grant_addr  = bus.i_addr;
                    end
                    we_d = grant_we;
`ifdef MEM_ARB_FAIRNESS_EN
                    if (take_data && bus.i_req) begin
                        streak_d = streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
`endif
                    if (grant_addr >= MEMORY_SIZE) begin
                        state_d    = ARB_RESP;
                        resp_fire  = 1'b1;
                        resp_err   = 1'b1;
                        resp_owner = owner_d;
                    end else begin
                        state_d     = ARB_ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = grant_we;
                        mem_addr_d  = grant_addr;
                        mem_wdata_d = grant_wdata;
                    end
                end
            end
            ARB_ISSUE: begin
                state_d   = ARB_WAIT;
                lat_cnt_d = LAT_W'(MEM_LATENCY - 1);
            end
            ARB_WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d   = ARB_RESP;
                    resp_fire = 1'b1;
                    resp_data = (we_q != 4'b0000) ? 32'h0 : bus.mem_rdata;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ARB_RESP: begin
                // Requests are not looked at here, so a request still high
                // during its own ack cannot be granted twice.
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        if (resp_fire) begin
            if (resp_owner == OWN_DATA) begin
                d_ack_d   = 1'b1;
                d_rdata_d = resp_data;
                d_err_d   = resp_err;
            end else begin
                i_ack_d   = 1'b1;
                i_rdata_d = resp_data;
                i_err_d   = resp_err;
            end
        end

        busy_d = (state_d != ARB_IDLE);
    end

    // State and output registers. Reset clears everything, which also
    // drops any access in flight without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_NONE;
            we_q        <= 4'b0000;
            lat_cnt_q   <= '0;
            i_ack_q     <= 1'b0;
            i_rdata_q   <= 32'h0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= 32'h0;
            d_err_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
            streak_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            lat_cnt_q   <= lat_cnt_d;
            i_ack_q     <= i_ack_d;
            i_rdata_q   <= i_rdata_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_FAIRNESS_EN
            streak_q    <= streak_d;
`endif
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Bench for mem_port_arbiter with MEM_LATENCY=2 and MAX_DATA_STREAK=4.
// A RAM model answers the memory port with data valid only exactly
// MEM_LATENCY cycles after mem_en (garbage otherwise). A transaction-level
// reference model predicts the winner, ack cycle, memory strobes and the
// returned word from a shadow memory fed only by requester-side stores.
// Honours MEM_ARB_FAIRNESS_EN when predicting grants.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LAT    = 2;
    localparam int STREAK = 4;
    localparam int WORDS  = 16384;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MEM_LATENCY    (LAT),
        .MAX_DATA_STREAK(STREAK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Initial memory contents shared by the RAM model and the shadow copy.
    function automatic logic [31:0] initWord(input int w);
        if (w == 32'h40) return 32'hDEAD_BEEF;
        return 32'(w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // RAM model: writes on mem_en, read data delayed through a LAT-deep pipe.
    bit   [31:0] ram     [WORDS];
    bit          ram_wr  [WORDS];
    logic [31:0] rd_pipe [LAT];
    assign bus.mem_rdata = rd_pipe[LAT-1];

    // Returns the word for each strobe LAT cycles later; garbage between.
    always @(posedge clk) begin : env_ram
        logic [31:0] cur;
        logic [31:0] merged;
        int          w;
        w   = int'(bus.mem_addr[15:2]);
        cur = ram_wr[w] ? ram[w] : initWord(w);
        if (bus.mem_en) begin
            merged = cur;
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) merged[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            end
            if (bus.mem_we != 4'b0000) begin
                ram[w]    <= merged;
                ram_wr[w] <= 1'b1;
            end
            rd_pipe[0] <= cur;
        end else begin
            rd_pipe[0] <= 32'hBAD0_0000 ^ 32'($urandom_range(0, 65535));
        end
        for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    // Reference model state.
    bit [31:0]   ref_mem [WORDS];
    bit          ref_wr  [WORDS];
    int          streak_m = 0;
    logic [31:0] exp_i_rdata = 32'h0, exp_d_rdata = 32'h0;
    logic        exp_i_err = 1'b0, exp_d_err = 1'b0;
    bit          i_pend = 0, d_pend = 0;

    function automatic logic [31:0] refRead(input int w);
        return ref_wr[w] ? ref_mem[w] : initWord(w);
    endfunction

    task automatic refWrite(input int w, input logic [3:0] we, input logic [31:0] wd);
        logic [31:0] cur;
        cur = refRead(w);
        for (int b = 0; b < 4; b++) if (we[b]) cur[8*b +: 8] = wd[8*b +: 8];
        ref_mem[w] = cur;
        ref_wr[w]  = 1'b1;
    endtask

    function automatic bit modelPicksData(input bit ireq, input bit dreq);
`ifdef MEM_ARB_FAIRNESS_EN
        return dreq && !(ireq && streak_m >= STREAK);
`else
        return dreq;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [3:0] dwe,
                                 input logic [31:0] daddr, input logic [31:0] dwdata);
        bus.i_req   = ireq;
        bus.i_addr  = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " i_ack"},     32'(bus.i_ack),  32'h0);
        checkOutput({tag, " i_rdata"},   bus.i_rdata,     32'h0);
        checkOutput({tag, " i_err"},     32'(bus.i_err),  32'h0);
        checkOutput({tag, " d_ack"},     32'(bus.d_ack),  32'h0);
        checkOutput({tag, " d_rdata"},   bus.d_rdata,     32'h0);
        checkOutput({tag, " d_err"},     32'(bus.d_err),  32'h0);
        checkOutput({tag, " mem_en"},    32'(bus.mem_en), 32'h0);
        checkOutput({tag, " mem_we"},    32'(bus.mem_we), 32'h0);
        checkOutput({tag, " mem_addr"},  bus.mem_addr,    32'h0);
        checkOutput({tag, " mem_wdata"}, bus.mem_wdata,   32'h0);
        checkOutput({tag, " busy"},      32'(bus.busy),   32'h0);
    endtask

    // Runs one access starting from an IDLE cycle with requests driven,
    // checking every cycle up to the ack and the following IDLE cycle.
    task automatic doTransaction(input string tag, output bit data_won);
        bit          is_data, err;
        logic [31:0] addr, wdata, exp_rdata;
        logic [3:0]  we;
        int          ack_off, w;
        is_data = modelPicksData(bus.i_req, bus.d_req);
`ifdef MEM_ARB_FAIRNESS_EN
        if (is_data) streak_m = bus.i_req ? streak_m + 1 : 0;
        else         streak_m = 0;
`endif
        addr  = is_data ? bus.d_addr  : bus.i_addr;
        we    = is_data ? bus.d_we    : 4'b0000;
        wdata = is_data ? bus.d_wdata : 32'h0;
        err   = (addr >= 32'h0001_0000);
        w     = int'(addr[15:2]);
        if (err) begin
            exp_rdata = 32'h0;
        end else if (we != 4'b0000) begin
            exp_rdata = 32'h0;
            refWrite(w, we, wdata);
        end else begin
            exp_rdata = refRead(w);
        end
        ack_off = err ? 1 : LAT + 2;
        for (int off = 1; off <= ack_off; off++) begin
            tick();
            checkOutput({tag, " busy"},   32'(bus.busy),   32'h1);
            checkOutput({tag, " mem_en"}, 32'(bus.mem_en), 32'(!err && off == 1));
            if (!err && off == 1) begin
                checkOutput({tag, " mem_addr"},  bus.mem_addr,    addr);
                checkOutput({tag, " mem_we"},    32'(bus.mem_we), 32'(we));
                checkOutput({tag, " mem_wdata"}, bus.mem_wdata,   wdata);
            end
            checkOutput({tag, " i_ack"}, 32'(bus.i_ack), 32'(!is_data && off == ack_off));
            checkOutput({tag, " d_ack"}, 32'(bus.d_ack), 32'(is_data && off == ack_off));
        end
        if (is_data) begin
            exp_d_rdata = exp_rdata;
            exp_d_err   = err;
        end else begin
            exp_i_rdata = exp_rdata;
            exp_i_err   = err;
        end
        checkOutput({tag, " i_rdata"}, bus.i_rdata,     exp_i_rdata);
        checkOutput({tag, " i_err"},   32'(bus.i_err),  32'(exp_i_err));
        checkOutput({tag, " d_rdata"}, bus.d_rdata,     exp_d_rdata);
        checkOutput({tag, " d_err"},   32'(bus.d_err),  32'(exp_d_err));
        if (is_data) bus.d_req = 1'b0;
        else         bus.i_req = 1'b0;
        tick();
        checkOutput({tag, " idle busy"},  32'(bus.busy),  32'h0);
        checkOutput({tag, " idle i_ack"}, 32'(bus.i_ack), 32'h0);
        checkOutput({tag, " idle d_ack"}, 32'(bus.d_ack), 32'h0);
        data_won = is_data;
    endtask

    function automatic logic [31:0] randAddr();
        if ($urandom_range(0, 7) == 0) return 32'h0001_0000 + 32'($urandom_range(0, 255) << 2);
        return 32'($urandom_range(0, WORDS - 1) << 2);
    endfunction

    initial begin
        bit dw;
        int fetch_wins, first_fetch, exp_fetch, exp_first;

        // Reset state.
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        // Fetch from 0x100 returns the preloaded 0xDEADBEEF at cycle 4.
        applyStimulus(1'b1, 32'h100, 1'b0, 4'b0000, 32'h0, 32'h0);
        doTransaction("fetch", dw);
        checkOutput("fetch word", bus.i_rdata, 32'hDEAD_BEEF);

        // Simultaneous requests: store goes first, fetch follows.
        applyStimulus(1'b1, 32'h104, 1'b1, 4'b1111, 32'h200, 32'h1234_5678);
        doTransaction("both/data", dw);
        checkOutput("both first winner", 32'(dw), 32'h1);
        doTransaction("both/fetch", dw);
        checkOutput("both second winner", 32'(dw), 32'h0);

        // Read back the stored word.
        applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 32'h200, 32'h0);
        doTransaction("readback", dw);
        checkOutput("readback word", bus.d_rdata, 32'h1234_5678);

        // Out-of-range load answers with an error one cycle later.
        applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 32'h0001_0000, 32'h0);
        doTransaction("range", dw);
        checkOutput("range err", 32'(bus.d_err), 32'h1);

        // Reset during WAIT abandons the fetch.
        applyStimulus(1'b1, 32'h300, 1'b0, 4'b0000, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        checkAllZero("async reset");
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
        streak_m    = 0;
        exp_i_rdata = 32'h0;
        exp_i_err   = 1'b0;
        exp_d_rdata = 32'h0;
        exp_d_err   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput("post-reset i_ack", 32'(bus.i_ack), 32'h0);
            checkOutput("post-reset busy",  32'(bus.busy),  32'h0);
        end
        applyStimulus(1'b1, 32'h300, 1'b0, 4'b0000, 32'h0, 32'h0);
        doTransaction("after reset", dw);

        // Both requesters held high: streak behaviour.
        applyStimulus(1'b1, 32'h104, 1'b1, 4'b0000, 32'h200, 32'h0);
        fetch_wins  = 0;
        first_fetch = -1;
        for (int n = 0; n < 12; n++) begin
            doTransaction("streak", dw);
            if (!dw) begin
                fetch_wins++;
                if (first_fetch < 0) first_fetch = n;
                bus.i_req = 1'b1;
            end else begin
                bus.d_req = 1'b1;
            end
        end
`ifdef MEM_ARB_FAIRNESS_EN
        exp_fetch = 2;
        exp_first = 4;
`else
        exp_fetch = 0;
        exp_first = -1;
`endif
        checkOutput("streak fetch grants", 32'(fetch_wins),  32'(exp_fetch));
        checkOutput("streak first fetch",  32'(first_fetch), 32'(exp_first));
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
        tick();

        // Randomised traffic; a requester keeps its request until acked.
        for (int n = 0; n < 40; n++) begin
            if (!i_pend && $urandom_range(0, 1) != 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = randAddr();
                i_pend     = 1;
            end
            if (!d_pend && $urandom_range(0, 1) != 0) begin
                bus.d_req   = 1'b1;
                bus.d_addr  = randAddr();
                bus.d_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                bus.d_wdata = $urandom;
                d_pend      = 1;
            end
            if (!i_pend && !d_pend) begin
                tick();
                checkOutput("rand idle busy", 32'(bus.busy), 32'h0);
            end else begin
                doTransaction("rand", dw);
                if (dw) d_pend = 0;
                else    i_pend = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
